issue_scoreboard: RTL and testbench

- Tracks destination registers of in-flight long-latency ops (loads, multi-cycle units) for the dual-issue pipeline.
- Sits beside the issue stage and decides, per cycle, whether issued slot 0 and slot 1 may leave issue.
- Holds a per-register busy bit, set on issue and cleared on regfile writeback, plus a bounded outstanding-op counter.
- Combinational stall, registered state; complements the same-pair dependency check already done in issue.

---
 rtl/issue_scoreboard_pkg.sv | 62 ++++++
 rtl/issue_scoreboard_if.sv | 28 ++
 rtl/issue_scoreboard_checker.sv | 20 ++
 rtl/issue_scoreboard_hazard.sv | 52 +++++
 rtl/issue_scoreboard.sv | 98 +++++++++
 tb/tb_issue_scoreboard.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: register-file geometry, the
// per-slot issue descriptor and small decode helpers used by the hazard logic.
package issue_scoreboard_pkg;

    localparam int REG_ADDR_W          = 5;
    localparam int NUM_REGS            = 32;
    localparam int DEFAULT_MAX_PENDING = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rs1_active;
        logic                  rs2_active;
        logic                  regwrite;
        logic                  is_long;
    } slot_t;

    localparam slot_t SLOT_IDLE = slot_t'(20'd0);

    // A slot that would allocate a busy bit if it fires.
    function automatic logic tracks(input slot_t s);
        if (s.valid && s.regwrite && s.is_long && (s.rd != 5'd0)) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

    function automatic logic src_hazard(input logic active, input logic [REG_ADDR_W-1:0] addr,
                                        input logic [NUM_REGS-1:0] busy);
        if (active && (addr != 5'd0)) begin
            return busy[addr];
        end else begin
            return 1'b0;
        end
    endfunction

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr,
                                                       input logic en);
        logic [NUM_REGS-1:0] mask;
        mask = 32'd0;
        if (en) begin
            mask[addr] = 1'b1;
        end else begin
            mask = 32'd0;
        end
        return mask;
    endfunction

    // Writeback only counts when it retires a register that is actually busy.
    function automatic logic wb_hit(input logic done, input logic [REG_ADDR_W-1:0] addr,
                                    input logic [NUM_REGS-1:0] busy);
        if (done && (addr != 5'd0)) begin
            return busy[addr];
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-stage <-> scoreboard bundle: both issue slots, both writeback ports,
// and the stall / tracking status returned to the pipeline.
interface issue_scoreboard_if
    import issue_scoreboard_pkg::*;
#(
    parameter int CNT_W = 4
);
    slot_t                 slot0;
    slot_t                 slot1;
    logic                  wb0_done;
    logic [REG_ADDR_W-1:0] wb0_addr;
    logic                  wb1_done;
    logic [REG_ADDR_W-1:0] wb1_addr;
    logic                  stall0;
    logic                  stall1;
    logic [NUM_REGS-1:0]   busy;
    logic [CNT_W-1:0]      pending;

    modport master (
        output slot0, slot1, wb0_done, wb0_addr, wb1_done, wb1_addr,
        input  stall0, stall1, busy, pending
    );

    modport slave (
        input  slot0, slot1, wb0_done, wb0_addr, wb1_done, wb1_addr,
        output stall0, stall1, busy, pending
    );
endinterface

// File: rtl/issue_scoreboard_checker.sv
// Bound checks on scoreboard state; observes the top's internal next-count.
module issue_scoreboard_checker
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int CNT_W       = 4
) (
    input logic                clock_i,
    input logic                reset_i,
    input logic                flush_i,
    input logic [CNT_W+1:0]    pending_ext,
    input logic [NUM_REGS-1:0] busy
);
    // An underflow wraps to a large value, so one upper bound covers both directions.
    a_pending_bound: assert property (@(posedge clock_i) disable iff (reset_i || flush_i)
        pending_ext <= (CNT_W+2)'(MAX_PENDING));

    a_x0_never_busy: assert property (@(posedge clock_i) disable iff (reset_i)
        busy[0] == 1'b0);
endmodule

// File: rtl/issue_scoreboard_hazard.sv
// Per-slot hazard check against the registered busy vector and pending count.
// The older-slot inputs add the in-pair ordering terms for the younger slot.
module scoreboard_hazard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int CNT_W       = 4
) (
    input  slot_t               slot,
    input  slot_t               older,
    input  logic                has_older,
    input  logic                older_stall,
    input  logic [NUM_REGS-1:0] busy,
    input  logic [CNT_W-1:0]    pending,
    output logic                stall
);
    logic             own_long_s;
    logic             older_long_s;
    logic             raw_s;
    logic             waw_s;
    logic             cap_s;
    logic             pair_dep_s;
    logic             pair_cap_s;
    logic [CNT_W+1:0] pending_plus2_s;

    // Combine own hazards with the in-order and same-pair terms.
    always_comb begin
        own_long_s      = slot.valid && slot.regwrite && slot.is_long;
        older_long_s    = older.valid && older.regwrite && older.is_long;
        pending_plus2_s = {2'b00, pending} + (CNT_W+2)'(2'd2);
        raw_s = slot.valid && (src_hazard(slot.rs1_active, slot.rs1, busy) ||
                               src_hazard(slot.rs2_active, slot.rs2, busy));
        waw_s = own_long_s && (slot.rd != 5'd0) && busy[slot.rd];
        cap_s = own_long_s && (pending == CNT_W'(MAX_PENDING));
        pair_dep_s = 1'b0;
        pair_cap_s = 1'b0;
        if (has_older) begin
            // Older slot's long result is not yet visible in busy this cycle.
            pair_dep_s = tracks(older) && slot.valid &&
                         ((slot.rs1_active && (slot.rs1 == older.rd)) ||
                          (slot.rs2_active && (slot.rs2 == older.rd)) ||
                          (slot.regwrite   && (slot.rd  == older.rd)));
            pair_cap_s = older_long_s && own_long_s &&
                         (pending_plus2_s > (CNT_W+2)'(MAX_PENDING));
        end else begin
            pair_dep_s = 1'b0;
            pair_cap_s = 1'b0;
        end
        stall = older_stall || raw_s || waw_s || cap_s || pair_dep_s || pair_cap_s;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard: per-register busy bits for in-flight long ops, a
// bounded pending counter, and combinational stalls for both issue slots.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int CNT_W       = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    issue_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [CNT_W-1:0]    pending_r;
    logic [CNT_W-1:0]    pending_next_s;
    logic [CNT_W+1:0]    pending_ext_s;
    logic [1:0]          set_cnt_s;
    logic [1:0]          clr_cnt_s;
    logic                stall0_s;
    logic                stall1_s;
    logic                track0_s;
    logic                track1_s;
    logic                clr0_s;
    logic                clr1_s;

    scoreboard_hazard #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_hazard0 (
        .slot        (sb.slot0),
        .older       (SLOT_IDLE),
        .has_older   (1'b0),
        .older_stall (1'b0),
        .busy        (busy_r),
        .pending     (pending_r),
        .stall       (stall0_s)
    );

    scoreboard_hazard #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_hazard1 (
        .slot        (sb.slot1),
        .older       (sb.slot0),
        .has_older   (1'b1),
        .older_stall (stall0_s),
        .busy        (busy_r),
        .pending     (pending_r),
        .stall       (stall1_s)
    );

    // Allocation from fired slots, retirement from writeback, next-state merge.
    always_comb begin
        track0_s = tracks(sb.slot0) && !stall0_s;
        track1_s = tracks(sb.slot1) && !stall1_s;
        clr0_s   = wb_hit(sb.wb0_done, sb.wb0_addr, busy_r);
        // Both ports retiring the same register is a single retirement.
        if (clr0_s && (sb.wb1_addr == sb.wb0_addr)) begin
            clr1_s = 1'b0;
        end else begin
            clr1_s = wb_hit(sb.wb1_done, sb.wb1_addr, busy_r);
        end
        set_mask_s  = reg_onehot(sb.slot0.rd, track0_s) | reg_onehot(sb.slot1.rd, track1_s);
        clr_mask_s  = reg_onehot(sb.wb0_addr, clr0_s) | reg_onehot(sb.wb1_addr, clr1_s);
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_next_s[0] = 1'b0;
        set_cnt_s = {1'b0, track0_s} + {1'b0, track1_s};
        clr_cnt_s = {1'b0, clr0_s} + {1'b0, clr1_s};
        pending_ext_s  = {2'b00, pending_r} + (CNT_W+2)'(set_cnt_s) - (CNT_W+2)'(clr_cnt_s);
        pending_next_s = pending_ext_s[CNT_W-1:0];
    end

    // Tracking state; reset dominates flush, both clear everything.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_r    <= 32'd0;
            pending_r <= CNT_W'(0);
        end else if (flush_i) begin
            busy_r    <= 32'd0;
            pending_r <= CNT_W'(0);
        end else begin
            busy_r    <= busy_next_s;
            pending_r <= pending_next_s;
        end
    end

    assign sb.stall0  = stall0_s;
    assign sb.stall1  = stall1_s;
    assign sb.busy    = busy_r;
    assign sb.pending = pending_r;

    issue_scoreboard_checker #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_checker (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .pending_ext (pending_ext_s),
        .busy        (busy_r)
    );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, a latency sequence, and
// randomized traffic against a reference model of the scoreboard rules.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int MAXP = 4;

    typedef struct {
        slot_t       s0;
        slot_t       s1;
        logic        d0;
        logic [4:0]  a0;
        logic        d1;
        logic [4:0]  a1;
        logic        fl;
        logic        e0;
        logic        e1;
        logic [31:0] eb;
        int          ep;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad = 0;
    bit   mb[32];
    int   mp;
    vec_t tv[$];

    issue_scoreboard_if #(.CNT_W(4)) sb_if();

    issue_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(4)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .flush_i (flush),
        .sb      (sb_if.slave)
    );

    always #5 clk = ~clk;

    function automatic slot_t ld(input logic [4:0] rd);
        slot_t s = SLOT_IDLE;
        s.valid = 1'b1; s.rd = rd; s.regwrite = 1'b1; s.is_long = 1'b1;
        return s;
    endfunction

    function automatic slot_t alu(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        slot_t s = SLOT_IDLE;
        s.valid = 1'b1; s.rs1 = r1; s.rs2 = r2; s.rd = rd;
        s.rs1_active = 1'b1; s.rs2_active = 1'b1; s.regwrite = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] bm(input int a, input int b, input int c, input int d);
        logic [31:0] r = 32'd0;
        if (a != 0) r[a] = 1'b1;
        if (b != 0) r[b] = 1'b1;
        if (c != 0) r[c] = 1'b1;
        if (d != 0) r[d] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mkv(input slot_t s0, input slot_t s1, input logic d0, input logic [4:0] a0,
                                 input logic d1, input logic [4:0] a1, input logic fl,
                                 input logic e0, input logic e1, input logic [31:0] eb, input int ep);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.d0 = d0; v.a0 = a0; v.d1 = d1; v.a1 = a1; v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input slot_t a, input slot_t b, input logic d0, input logic [4:0] a0,
                         input logic d1, input logic [4:0] a1, input logic fl);
        sb_if.slot0 = a; sb_if.slot1 = b;
        sb_if.wb0_done = d0; sb_if.wb0_addr = a0;
        sb_if.wb1_done = d1; sb_if.wb1_addr = a1;
        flush = fl;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v.s0, v.s1, v.d0, v.a0, v.d1, v.a1, v.fl);
        #1;
        chk({tag, " stall0"}, 32'(sb_if.stall0), 32'(v.e0));
        chk({tag, " stall1"}, 32'(sb_if.stall1), 32'(v.e1));
        @(posedge clk);
        #1;
        chk({tag, " busy"}, sb_if.busy, v.eb);
        chk({tag, " pending"}, 32'(sb_if.pending), 32'(v.ep));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(SLOT_IDLE, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mb[r] = 1'b0;
        mp = 0;
    endtask

    // Reference model: stall rules evaluated on the model's start-of-cycle state.
    function automatic bit m_lw(input slot_t s);
        return s.valid && s.regwrite && s.is_long;
    endfunction

    function automatic bit m_own(input slot_t s);
        bit raw = s.valid && ((s.rs1_active && s.rs1 != 5'd0 && mb[s.rs1]) ||
                              (s.rs2_active && s.rs2 != 5'd0 && mb[s.rs2]));
        bit waw = m_lw(s) && s.rd != 5'd0 && mb[s.rd];
        bit cap = m_lw(s) && (mp == MAXP);
        return raw || waw || cap;
    endfunction

    task automatic m_stalls(input slot_t a, input slot_t b, output bit st0, output bit st1);
        bit dep;
        bit pair;
        st0  = m_own(a);
        dep  = m_lw(a) && a.rd != 5'd0 && b.valid &&
               ((b.rs1_active && b.rs1 == a.rd) || (b.rs2_active && b.rs2 == a.rd) ||
                (b.regwrite && b.rd == a.rd));
        pair = m_lw(a) && m_lw(b) && (mp + 2 > MAXP);
        st1  = st0 || m_own(b) || dep || pair;
    endtask

    task automatic m_update(input slot_t a, input slot_t b, input bit st0, input bit st1,
                            input logic d0, input logic [4:0] a0, input logic d1,
                            input logic [4:0] a1, input logic fl);
        int clr[$];
        int st[$];
        if (fl) begin
            for (int r = 0; r < 32; r++) mb[r] = 1'b0;
            mp = 0;
        end else begin
            if (d0 && a0 != 5'd0 && mb[a0]) clr.push_back(int'(a0));
            if (d1 && a1 != 5'd0 && mb[a1] && !(clr.size() > 0 && clr[0] == int'(a1)))
                clr.push_back(int'(a1));
            if (!st0 && m_lw(a) && a.rd != 5'd0) st.push_back(int'(a.rd));
            if (b.valid && !st1 && m_lw(b) && b.rd != 5'd0) st.push_back(int'(b.rd));
            foreach (clr[k]) mb[clr[k]] = 1'b0;
            foreach (st[k]) mb[st[k]] = 1'b1;
            mp = mp + st.size() - clr.size();
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] r = 32'd0;
        for (int k = 0; k < 32; k++) r[k] = mb[k];
        return r;
    endfunction

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic slot_t rslot();
        slot_t s;
        s.valid = ($urandom_range(0, 3) != 0);
        s.rs1 = rreg(); s.rs2 = rreg(); s.rd = rreg();
        s.rs1_active = 1'($urandom_range(0, 1));
        s.rs2_active = 1'($urandom_range(0, 1));
        s.regwrite = ($urandom_range(0, 3) != 0);
        s.is_long = 1'($urandom_range(0, 1));
        return s;
    endfunction

    initial begin
        slot_t l20;
        slot_t u20;
        rst = 1'b1;
        flush = 1'b0;
        drive(SLOT_IDLE, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        do_reset();

        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(0,0,0,0), 0));
        tv.push_back(mkv(ld(5'd5), SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(5,0,0,0), 1));
        tv.push_back(mkv(alu(5'd5,5'd0,5'd6), SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, bm(5,0,0,0), 1));
        tv.push_back(mkv(alu(5'd5,5'd0,5'd6), SLOT_IDLE, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, bm(0,0,0,0), 0));
        tv.push_back(mkv(alu(5'd5,5'd0,5'd6), SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(0,0,0,0), 0));
        tv.push_back(mkv(ld(5'd7), alu(5'd7,5'd1,5'd8), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, bm(7,0,0,0), 1));
        tv.push_back(mkv(SLOT_IDLE, alu(5'd7,5'd1,5'd8), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, bm(7,0,0,0), 1));
        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, bm(0,0,0,0), 0));
        tv.push_back(mkv(ld(5'd1), ld(5'd2), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(1,2,0,0), 2));
        tv.push_back(mkv(ld(5'd3), ld(5'd4), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(1,2,3,4), 4));
        tv.push_back(mkv(ld(5'd10), SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, bm(1,2,3,4), 4));
        tv.push_back(mkv(ld(5'd10), SLOT_IDLE, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, bm(2,3,4,0), 3));
        tv.push_back(mkv(ld(5'd10), SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(2,3,4,10), 4));
        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b1, 5'd2, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, bm(3,4,10,0), 3));
        tv.push_back(mkv(ld(5'd11), ld(5'd12), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, bm(3,4,10,11), 4));
        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, bm(4,10,11,0), 3));
        tv.push_back(mkv(ld(5'd9), SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(4,9,10,11), 4));
        tv.push_back(mkv(ld(5'd9), SLOT_IDLE, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, bm(4,10,11,0), 3));
        tv.push_back(mkv(ld(5'd9), SLOT_IDLE, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(4,9,10,11), 4));
        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b1, 5'd4, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, bm(9,11,0,0), 2));
        tv.push_back(mkv(ld(5'd13), alu(5'd1,5'd2,5'd13), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, bm(9,11,13,0), 3));
        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, bm(0,0,0,0), 0));
        tv.push_back(mkv(SLOT_IDLE, SLOT_IDLE, 1'b1, 5'd9, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, bm(0,0,0,0), 0));
        l20 = alu(5'd0, 5'd0, 5'd0);
        l20.is_long = 1'b1;
        tv.push_back(mkv(l20, ld(5'd0), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(0,0,0,0), 0));

        for (int i = 0; i < tv.size(); i++) begin
            run_vec(tv[i], $sformatf("vec%0d", i));
        end

        // Consumer of a long op: held from the cycle after issue until after the wb edge.
        l20 = ld(5'd20);
        u20 = alu(5'd20, 5'd0, 5'd21);
        run_vec(mkv(l20, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(20,0,0,0), 1), "lat issue");
        for (int k = 0; k < 3; k++) begin
            run_vec(mkv(u20, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, bm(20,0,0,0), 1),
                    $sformatf("lat wait%0d", k));
        end
        run_vec(mkv(u20, SLOT_IDLE, 1'b0, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b1, bm(0,0,0,0), 0), "lat wb");
        run_vec(mkv(u20, SLOT_IDLE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bm(0,0,0,0), 0), "lat go");

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            slot_t a;
            slot_t b;
            logic d0, d1, fl;
            logic [4:0] a0, a1;
            bit st0, st1;
            a = rslot(); b = rslot();
            d0 = ($urandom_range(0, 2) == 0); a0 = rreg();
            d1 = ($urandom_range(0, 2) == 0); a1 = rreg();
            fl = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            drive(a, b, d0, a0, d1, a1, fl);
            m_stalls(a, b, st0, st1);
            #1;
            chk($sformatf("rnd%0d stall0", c), 32'(sb_if.stall0), 32'(st0));
            chk($sformatf("rnd%0d stall1", c), 32'(sb_if.stall1), 32'(st1));
            @(posedge clk);
            m_update(a, b, st0, st1, d0, a0, d1, a1, fl);
            #1;
            chk($sformatf("rnd%0d busy", c), sb_if.busy, m_busy());
            chk($sformatf("rnd%0d pending", c), 32'(sb_if.pending), 32'(mp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
